// File: rtl/ram_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter_ctrl
// Function : Round-robin req/gnt arbiter sharing one single-port sync RAM
//            between two requesters; clears the RAM after every reset.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter_ctrl #(
    parameter int                ADDR_W    = 5,
    parameter int                DATA_W    = 4,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata,
    output logic              init_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic [1:0] {
        S_CLEAR     = 2'd0,
        S_IDLE      = 2'd1,
        S_ACCESS    = 2'd2,
        S_READ_WAIT = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_last_addr = '1;

    state_t            r_state,     w_state_nxt;
    logic [ADDR_W-1:0] r_clr_addr,  w_clr_addr_nxt;
    logic              r_last_b,    w_last_b_nxt;
    logic              r_gnt_a,     w_gnt_a_nxt;
    logic              r_gnt_b,     w_gnt_b_nxt;
    logic              r_rvalid_a,  w_rvalid_a_nxt;
    logic              r_rvalid_b,  w_rvalid_b_nxt;
    logic [DATA_W-1:0] r_rdata,     w_rdata_nxt;
    logic              r_init_done, w_init_done_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_data,  w_mem_data_nxt;
    logic              r_mem_wren,  w_mem_wren_nxt;
    logic              w_pick_b;

    // On a tie the requester that was not granted last wins.
    assign w_pick_b = req_b & (~req_a | ~r_last_b);

    always_comb begin
        w_state_nxt     = r_state;
        w_clr_addr_nxt  = r_clr_addr;
        w_last_b_nxt    = r_last_b;
        w_gnt_a_nxt     = 1'b0;
        w_gnt_b_nxt     = 1'b0;
        w_rvalid_a_nxt  = 1'b0;
        w_rvalid_b_nxt  = 1'b0;
        w_rdata_nxt     = r_rdata;
        w_init_done_nxt = r_init_done;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_data_nxt  = r_mem_data;
        w_mem_wren_nxt  = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_mem_wren_nxt = 1'b1;
                w_mem_addr_nxt = r_clr_addr;
                w_mem_data_nxt = CLEAR_VAL;
                if (r_clr_addr == c_last_addr) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + 1'b1;
                end
            end
            S_IDLE: begin
                w_init_done_nxt = 1'b1;
                if (req_a || req_b) begin
                    w_gnt_a_nxt    = ~w_pick_b;
                    w_gnt_b_nxt    = w_pick_b;
                    w_mem_addr_nxt = w_pick_b ? addr_b  : addr_a;
                    w_mem_data_nxt = w_pick_b ? wdata_b : wdata_a;
                    w_mem_wren_nxt = w_pick_b ? we_b    : we_a;
                    w_last_b_nxt   = w_pick_b;
                    w_state_nxt    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // r_mem_wren still carries the granted access type here.
                w_state_nxt = r_mem_wren ? S_IDLE : S_READ_WAIT;
            end
            S_READ_WAIT: begin
                w_rdata_nxt    = mem_q;
                w_rvalid_a_nxt = ~r_last_b;
                w_rvalid_b_nxt = r_last_b;
                w_state_nxt    = S_IDLE;
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= S_CLEAR;
            r_clr_addr  <= '0;
            r_last_b    <= 1'b1;
            r_gnt_a     <= 1'b0;
            r_gnt_b     <= 1'b0;
            r_rvalid_a  <= 1'b0;
            r_rvalid_b  <= 1'b0;
            r_rdata     <= '0;
            r_init_done <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem_wren  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_addr  <= w_clr_addr_nxt;
            r_last_b    <= w_last_b_nxt;
            r_gnt_a     <= w_gnt_a_nxt;
            r_gnt_b     <= w_gnt_b_nxt;
            r_rvalid_a  <= w_rvalid_a_nxt;
            r_rvalid_b  <= w_rvalid_b_nxt;
            r_rdata     <= w_rdata_nxt;
            r_init_done <= w_init_done_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_data  <= w_mem_data_nxt;
            r_mem_wren  <= w_mem_wren_nxt;
        end
    end

    assign gnt_a     = r_gnt_a;
    assign gnt_b     = r_gnt_b;
    assign rvalid_a  = r_rvalid_a;
    assign rvalid_b  = r_rvalid_b;
    assign rdata     = r_rdata;
    assign init_done = r_init_done;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
    assign mem_wren  = r_mem_wren;

endmodule
`default_nettype wire
